buzzer_arbiter: RTL and testbench

- Shares the single board buzzer pin between three alarm requesters with fixed priority.
- Each requester is bound to a fixed beep pattern, which the block generates itself:
  - requester 0: click, 1 short beep
  - requester 1: warning, 2 short beeps
  - requester 2: alarm, 3 long beeps
- Arbitration is non-preemptive: a pattern, once granted, always plays to completion.
- Timing derives from the 50 MHz system clock through a 1 ms prescaler.

---
 rtl/buzzer_arbiter.sv | 137 +++++++++++++
 tb/tb_buzzer_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_arbiter.sv
// rtl/buzzer_arbiter.sv - fixed-priority, non-preemptive arbiter sharing one buzzer pin between three beep patterns
module buzzer_arbiter #(
    parameter logic [15:0] T1MS     = 16'd49_999,
    parameter logic [9:0]  SHORT_MS = 10'd100,
    parameter logic [9:0]  LONG_MS  = 10'd300,
    parameter logic [9:0]  GAP_MS   = 10'd50
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [2:0] Req,
    output logic [2:0] Req_Ack,
    output logic       Busy,
    output logic       Done,
    output logic       Pin_Out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_ON    = 3'd2,
        S_OFF   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  pend_q, pend_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  beeps_q, beeps_d;
    logic [9:0]  on_ms_q, on_ms_d;
    logic [15:0] cnt1_q, cnt1_d;
    logic [9:0]  cnt_ms_q, cnt_ms_d;
    logic [2:0]  ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pin_q, pin_d;
    logic [2:0]  grant_mask;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        beeps_d = beeps_q;
        on_ms_d = on_ms_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q != 3'b000) begin
                    state_d = S_GRANT;
                    if (pend_q[2])      idx_d = 2'd2;
                    else if (pend_q[1]) idx_d = 2'd1;
                    else                idx_d = 2'd0;
                end
            end
            S_GRANT: begin
                beeps_d = (idx_q == 2'd2) ? 2'd3 : ((idx_q == 2'd1) ? 2'd2 : 2'd1);
                on_ms_d = (idx_q == 2'd2) ? LONG_MS : SHORT_MS;
                state_d = S_ON;
            end
            S_ON: begin
                if (cnt_ms_q == on_ms_q) begin
                    beeps_d = beeps_q - 2'd1;
                    state_d = S_OFF;
                end
            end
            S_OFF: begin
                if (cnt_ms_q == GAP_MS) begin
                    state_d = (beeps_q != 2'd0) ? S_ON : S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Clear of the granted bit overrides a Req level arriving in the same cycle
    always_comb begin
        grant_mask = 3'b001 << idx_q;
        pend_d     = pend_q | Req;
        if (state_q == S_GRANT) begin
            pend_d = pend_d & ~grant_mask;
        end
    end

    // Prescaler and ms counter restart on every ON<->OFF change and idle outside the beep states
    always_comb begin
        cnt1_d   = 16'd0;
        cnt_ms_d = 10'd0;
        if ((state_q == S_ON || state_q == S_OFF) && state_d == state_q) begin
            if (cnt1_q == T1MS) begin
                cnt1_d   = 16'd0;
                cnt_ms_d = cnt_ms_q + 10'd1;
            end else begin
                cnt1_d   = cnt1_q + 16'd1;
                cnt_ms_d = cnt_ms_q;
            end
        end
    end

    always_comb begin
        ack_d  = (state_d == S_GRANT) ? (3'b001 << idx_d) : 3'b000;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        pin_d  = (state_d == S_ON);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_IDLE;
            pend_q   <= 3'b000;
            idx_q    <= 2'd0;
            beeps_q  <= 2'd0;
            on_ms_q  <= 10'd0;
            cnt1_q   <= 16'd0;
            cnt_ms_q <= 10'd0;
            ack_q    <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            idx_q    <= idx_d;
            beeps_q  <= beeps_d;
            on_ms_q  <= on_ms_d;
            cnt1_q   <= cnt1_d;
            cnt_ms_q <= cnt_ms_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pin_q    <= pin_d;
        end
    end

    assign Req_Ack = ack_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Pin_Out = pin_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb/tb_buzzer_arbiter.sv - directed table-driven bench for buzzer_arbiter
module tb_buzzer_arbiter;

    logic       CLK;
    logic       RSTn;
    logic [2:0] Req;
    logic [2:0] Req_Ack;
    logic       Busy;
    logic       Done;
    logic       Pin_Out;

    int total;
    int bad;

    buzzer_arbiter #(
        .T1MS    (16'd9),
        .SHORT_MS(10'd3),
        .LONG_MS (10'd6),
        .GAP_MS  (10'd2)
    ) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .Req    (Req),
        .Req_Ack(Req_Ack),
        .Busy   (Busy),
        .Done   (Done),
        .Pin_Out(Pin_Out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] req;
        logic [2:0] ack;
        int         nbeeps;
        int         on_len;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ack(input logic [2:0] exp, input int maxc, input string name);
        int n;
        n = 0;
        while (Req_Ack === 3'b000 && n < maxc) begin
            @(negedge CLK);
            n++;
        end
        chk(name, {29'd0, Req_Ack}, {29'd0, exp});
    endtask

    // Entered at the negedge where the grant is visible; leaves at the negedge after Done
    task automatic check_pattern(input int nb, input int on_len, input string name);
        int n;
        chk({name, "_busy_grant"}, {31'd0, Busy}, 32'd1);
        @(negedge CLK);
        for (int b = 0; b < nb; b++) begin
            n = 0;
            while (Pin_Out === 1'b1 && n < 1000) begin
                n++;
                @(negedge CLK);
            end
            chk({name, "_on_len"}, n, on_len);
            n = 0;
            while (Pin_Out === 1'b0 && Done !== 1'b1 && n < 1000) begin
                n++;
                @(negedge CLK);
            end
            chk({name, "_gap_len"}, n, 21);
        end
        chk({name, "_done"}, {31'd0, Done}, 32'd1);
        chk({name, "_busy_done"}, {31'd0, Busy}, 32'd1);
        @(negedge CLK);
        chk({name, "_done_single"}, {31'd0, Done}, 32'd0);
        chk({name, "_busy_fall"}, {31'd0, Busy}, 32'd0);
    endtask

    task automatic pulse_req(input logic [2:0] r);
        Req = r;
        @(negedge CLK);
        Req = 3'b000;
    endtask

    initial begin
        int n;
        int acks;
        int busy_cnt;
        int pin_cnt;
        total = 0;
        bad   = 0;

        vecs[0] = '{req: 3'b001, ack: 3'b001, nbeeps: 1, on_len: 31};
        vecs[1] = '{req: 3'b010, ack: 3'b010, nbeeps: 2, on_len: 31};
        vecs[2] = '{req: 3'b100, ack: 3'b100, nbeeps: 3, on_len: 61};

        RSTn = 1'b0;
        Req  = 3'b000;
        repeat (3) @(negedge CLK);
        chk("rst_pin", {31'd0, Pin_Out}, 32'd0);
        chk("rst_ack", {29'd0, Req_Ack}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 3; i++) begin
            pulse_req(vecs[i].req);
            chk("ack_not_early", {29'd0, Req_Ack}, 32'd0);
            @(negedge CLK);
            chk("ack_latency", {29'd0, Req_Ack}, {29'd0, vecs[i].ack});
            check_pattern(vecs[i].nbeeps, vecs[i].on_len, "vec");
            repeat (3) @(negedge CLK);
        end

        // All three at once: alarm, warning, click in order
        pulse_req(3'b111);
        chk("all_not_early", {29'd0, Req_Ack}, 32'd0);
        @(negedge CLK);
        chk("all_ack2", {29'd0, Req_Ack}, 32'd4);
        check_pattern(3, 61, "all_alarm");
        wait_ack(3'b010, 3, "all_ack1");
        check_pattern(2, 31, "all_warn");
        wait_ack(3'b001, 3, "all_ack0");
        check_pattern(1, 31, "all_click");
        acks = 0;
        repeat (50) begin
            @(negedge CLK);
            if (Req_Ack !== 3'b000) acks++;
        end
        chk("all_no_extra_ack", acks, 0);

        // Repeated clicks during an alarm merge into one
        pulse_req(3'b100);
        wait_ack(3'b100, 3, "merge_alarm_ack");
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            pulse_req(3'b001);
            repeat (19) begin
                if (Req_Ack !== 3'b000) acks++;
                @(negedge CLK);
            end
        end
        chk("merge_no_ack_during_alarm", acks, 0);
        n = 0;
        while (Done !== 1'b1 && n < 400) begin
            n++;
            @(negedge CLK);
        end
        chk("merge_alarm_done", {31'd0, Done}, 32'd1);
        wait_ack(3'b001, 4, "merge_click_ack");
        check_pattern(1, 31, "merge_click");
        acks = 0;
        repeat (100) begin
            @(negedge CLK);
            if (Req_Ack !== 3'b000) acks++;
        end
        chk("merge_single_click", acks, 0);

        // Reset during the second long beep
        pulse_req(3'b100);
        wait_ack(3'b100, 3, "rst_alarm_ack");
        n = 0;
        while (Pin_Out !== 1'b1 && n < 10) begin n++; @(negedge CLK); end
        n = 0;
        while (Pin_Out !== 1'b0 && n < 100) begin n++; @(negedge CLK); end
        n = 0;
        while (Pin_Out !== 1'b1 && n < 100) begin n++; @(negedge CLK); end
        pulse_req(3'b011);
        repeat (10) @(negedge CLK);
        chk("rst_in_beep2", {31'd0, Pin_Out}, 32'd1);
        #2;
        RSTn = 1'b0;
        #1;
        chk("rst_async_pin", {31'd0, Pin_Out}, 32'd0);
        chk("rst_async_busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        acks     = 0;
        busy_cnt = 0;
        pin_cnt  = 0;
        repeat (200) begin
            @(negedge CLK);
            if (Req_Ack !== 3'b000) acks++;
            if (Busy !== 1'b0) busy_cnt++;
            if (Pin_Out !== 1'b0) pin_cnt++;
        end
        chk("rst_no_ack", acks, 0);
        chk("rst_no_busy", busy_cnt, 0);
        chk("rst_no_pin", pin_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
